// File: rtl/cpu_pkg.sv
// Shared core definitions: instruction field positions, register constants
// and the load/store FSM state encoding.
// Pure declarations, no logic.
package cpu_pkg;

  // Single data transfer control bits within the instruction word
  localparam int unsigned L_BIT = 20;  // 1 = load
  localparam int unsigned W_BIT = 21;  // write-back
  localparam int unsigned B_BIT = 22;  // 1 = byte
  localparam int unsigned U_BIT = 23;  // 1 = add offset
  localparam int unsigned P_BIT = 24;  // 1 = pre-index

  // Program counter register number
  localparam logic [3:0] R15 = 4'd15;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACCESS = 2'd1,
    ST_RESP   = 2'd2
  } ldst_state_e;

endpackage

// File: rtl/ldst_align.sv
// Byte-lane steering for the load/store unit: byte enables, store-data
// replication and load rotate/lane extract.
// Purely combinational, zero latency, no flow control.
module ldst_align (
  input  logic        byte_acc,
  input  logic [1:0]  addr_lo,
  input  logic [31:0] sdata,
  input  logic [31:0] rdata,
  output logic [3:0]  be,
  output logic [31:0] wdata,
  output logic [31:0] ldata
);

  logic [31:0] rot;

  // Rotate read data right by 8 * addr_lo; the addressed byte lane then
  // sits at the bottom, which also serves the byte-load extract.
  always_comb begin
    rot = rdata;
    case (addr_lo)
      2'd1:    rot = {rdata[7:0],  rdata[31:8]};
      2'd2:    rot = {rdata[15:0], rdata[31:16]};
      2'd3:    rot = {rdata[23:0], rdata[31:24]};
      default: rot = rdata;
    endcase
  end

  // Lane enables, replicated store byte and final load value
  always_comb begin
    be    = 4'hF;
    wdata = sdata;
    ldata = rot;
    if (byte_acc) begin
      be    = 4'b0001 << addr_lo;
      wdata = {4{sdata[7:0]}};
      ldata = {24'd0, rot[7:0]};
    end
  end

endmodule

// File: rtl/ldst_unit.sv
// LDR/STR unit: address generation, one memory transaction, register-file response.
// Latency: accept -> response in 2 cycles with zero-wait memory, +1 per wait state.
// req_ready low while busy; memory stalls held by mem_req until ack or timeout.
module ldst_unit
  import cpu_pkg::*;
#(
  parameter int unsigned TIMEOUT = 255
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_load,
  input  logic        req_byte,
  input  logic        req_pre,
  input  logic        req_up,
  input  logic        req_wb,
  input  logic [3:0]  req_rn,
  input  logic [3:0]  req_rd,
  input  logic [31:0] req_base,
  input  logic [11:0] req_offset,
  input  logic [31:0] req_sdata,
  output logic        mem_req,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [3:0]  mem_be,
  output logic [31:0] mem_wdata,
  input  logic        mem_ack,
  input  logic [31:0] mem_rdata,
  output logic        rsp_valid,
  output logic        rsp_fault,
  output logic        rsp_ld_we,
  output logic [3:0]  rsp_rd,
  output logic [31:0] rsp_data,
  output logic        rsp_wb_we,
  output logic [3:0]  rsp_rn,
  output logic [31:0] rsp_base
);

  localparam int unsigned CW = $clog2(TIMEOUT + 1);

  ldst_state_e state_q, state_d;
  logic          load_q, load_d;
  logic          byte_q, byte_d;
  logic          wb_en_q, wb_en_d;
  logic [3:0]    rn_q, rn_d;
  logic [3:0]    rd_q, rd_d;
  logic [31:0]   addr_q, addr_d;
  logic [31:0]   base_q, base_d;
  logic [31:0]   sdata_q, sdata_d;
  logic [31:0]   data_q, data_d;
  logic          fault_q, fault_d;
  logic [CW-1:0] cnt_q, cnt_d;

  logic [31:0] base_upd;
  logic [31:0] eff_addr;
  logic        wb_allow;
  logic [3:0]  al_be;
  logic [31:0] al_wdata;
  logic [31:0] al_ldata;

  ldst_align u_align (
    .byte_acc (byte_q),
    .addr_lo  (addr_q[1:0]),
    .sdata    (sdata_q),
    .rdata    (mem_rdata),
    .be       (al_be),
    .wdata    (al_wdata),
    .ldata    (al_ldata)
  );

  // Address arithmetic and writeback qualification on the incoming request
  always_comb begin
    base_upd = req_up ? (req_base + {20'd0, req_offset})
                      : (req_base - {20'd0, req_offset});
    eff_addr = req_pre ? base_upd : req_base;
    // Post-index always writes back; a loaded Rd == Rn takes priority over the base
    wb_allow = (!req_pre || req_wb) && (req_rn != R15) &&
               !(req_load && (req_rd == req_rn));
  end

  // Next-state, request capture, wait counter and data capture
  always_comb begin
    state_d = state_q;
    load_d  = load_q;
    byte_d  = byte_q;
    wb_en_d = wb_en_q;
    rn_d    = rn_q;
    rd_d    = rd_q;
    addr_d  = addr_q;
    base_d  = base_q;
    sdata_d = sdata_q;
    data_d  = data_q;
    fault_d = fault_q;
    cnt_d   = cnt_q;
    case (state_q)
      ST_IDLE: begin
        if (req_valid) begin
          state_d = ST_ACCESS;
          load_d  = req_load;
          byte_d  = req_byte;
          wb_en_d = wb_allow;
          rn_d    = req_rn;
          rd_d    = req_rd;
          addr_d  = eff_addr;
          base_d  = base_upd;
          sdata_d = req_sdata;
          data_d  = 32'd0;
          fault_d = 1'b0;
          cnt_d   = '0;
        end
      end
      ST_ACCESS: begin
        // An ack on the last permitted cycle still completes normally
        if (mem_ack) begin
          state_d = ST_RESP;
          data_d  = load_q ? al_ldata : 32'd0;
        end else begin
          cnt_d = cnt_q + 1'b1;
          if (cnt_d == CW'(TIMEOUT)) begin
            state_d = ST_RESP;
            fault_d = 1'b1;
          end
        end
      end
      ST_RESP: begin
        state_d = ST_IDLE;
        cnt_d   = '0;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // State and captured-request registers
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= ST_IDLE;
      load_q  <= 1'b0;
      byte_q  <= 1'b0;
      wb_en_q <= 1'b0;
      rn_q    <= 4'd0;
      rd_q    <= 4'd0;
      addr_q  <= 32'd0;
      base_q  <= 32'd0;
      sdata_q <= 32'd0;
      data_q  <= 32'd0;
      fault_q <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      load_q  <= load_d;
      byte_q  <= byte_d;
      wb_en_q <= wb_en_d;
      rn_q    <= rn_d;
      rd_q    <= rd_d;
      addr_q  <= addr_d;
      base_q  <= base_d;
      sdata_q <= sdata_d;
      data_q  <= data_d;
      fault_q <= fault_d;
      cnt_q   <= cnt_d;
    end
  end

  // Outputs decode straight from state, so reset clears them without a clock
  always_comb begin
    req_ready = (state_q == ST_IDLE);
    mem_req   = (state_q == ST_ACCESS);
    mem_we    = mem_req && !load_q;
    mem_addr  = mem_req ? {addr_q[31:2], 2'b00} : 32'd0;
    mem_be    = mem_req ? al_be : 4'd0;
    mem_wdata = mem_req ? al_wdata : 32'd0;
    rsp_valid = (state_q == ST_RESP);
    rsp_fault = rsp_valid && fault_q;
    rsp_ld_we = rsp_valid && load_q && !fault_q;
    rsp_wb_we = rsp_valid && wb_en_q && !fault_q;
    rsp_rd    = rsp_valid ? rd_q : 4'd0;
    rsp_rn    = rsp_valid ? rn_q : 4'd0;
    rsp_data  = rsp_valid ? data_q : 32'd0;
    rsp_base  = rsp_valid ? base_q : 32'd0;
  end

endmodule

// File: tb/tb_ldst_unit.sv
// Self-checking bench for ldst_unit: directed cases plus randomized transfers
// checked against a behavioural model of the transfer rules.
// Memory side is modelled by the bench with a programmable wait count.
module tb_ldst_unit;
  import cpu_pkg::*;

  localparam int unsigned TO = 8;
  localparam int unsigned NEVER = 1000;

  logic        clk = 1'b0;
  logic        reset;
  logic        req_valid, req_ready;
  logic        req_load, req_byte, req_pre, req_up, req_wb;
  logic [3:0]  req_rn, req_rd;
  logic [31:0] req_base;
  logic [11:0] req_offset;
  logic [31:0] req_sdata;
  logic        mem_req, mem_we;
  logic [31:0] mem_addr;
  logic [3:0]  mem_be;
  logic [31:0] mem_wdata;
  logic        mem_ack;
  logic [31:0] mem_rdata;
  logic        rsp_valid, rsp_fault, rsp_ld_we, rsp_wb_we;
  logic [3:0]  rsp_rd, rsp_rn;
  logic [31:0] rsp_data, rsp_base;

  int n_checks = 0;
  int n_fail   = 0;

  ldst_unit #(.TIMEOUT(TO)) dut (
    .clk(clk), .reset(reset),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_load(req_load), .req_byte(req_byte), .req_pre(req_pre),
    .req_up(req_up), .req_wb(req_wb), .req_rn(req_rn), .req_rd(req_rd),
    .req_base(req_base), .req_offset(req_offset), .req_sdata(req_sdata),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_be(mem_be), .mem_wdata(mem_wdata),
    .mem_ack(mem_ack), .mem_rdata(mem_rdata),
    .rsp_valid(rsp_valid), .rsp_fault(rsp_fault), .rsp_ld_we(rsp_ld_we),
    .rsp_rd(rsp_rd), .rsp_data(rsp_data), .rsp_wb_we(rsp_wb_we),
    .rsp_rn(rsp_rn), .rsp_base(rsp_base)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  // Advance to just after the next rising edge
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Scramble request fields so the unit is seen to ignore them when busy
  task automatic scramble_req();
    req_load   = 1'($urandom);
    req_byte   = 1'($urandom);
    req_pre    = 1'($urandom);
    req_up     = 1'($urandom);
    req_wb     = 1'($urandom);
    req_rn     = 4'($urandom);
    req_rd     = 4'($urandom);
    req_base   = $urandom;
    req_offset = 12'($urandom);
    req_sdata  = $urandom;
  endtask

  // One full transfer: ack arrives after 'waits' idle ACCESS cycles
  // (waits >= TO means the memory never answers).
  task automatic do_txn(input logic ld, input logic by, input logic pre, input logic up,
                        input logic wb, input logic [3:0] rn, input logic [3:0] rd,
                        input logic [31:0] base, input logic [11:0] off,
                        input logic [31:0] sdata, input logic [31:0] rdata,
                        input int unsigned waits);
    logic [31:0] inst;
    logic [31:0] upd, ea, x_addr, x_wdata, x_data, rot;
    logic [3:0]  x_be;
    int unsigned k;
    bit          fault, x_ldwe, x_wbwe, acked;

    // Reference model
    upd     = up ? base + 32'(off) : base - 32'(off);
    ea      = pre ? upd : base;
    k       = int'(ea % 4);
    x_addr  = ea - (ea % 4);
    x_be    = by ? 4'(1 << k) : 4'hF;
    x_wdata = by ? {sdata[7:0], sdata[7:0], sdata[7:0], sdata[7:0]} : sdata;
    fault   = (waits >= TO);
    rot     = (k == 0) ? rdata : ((rdata >> (8 * k)) | (rdata << (32 - 8 * k)));
    x_ldwe  = ld && !fault;
    x_data  = !x_ldwe ? 32'd0 : (by ? ((rdata >> (8 * k)) & 32'hFF) : rot);
    x_wbwe  = !fault && (!pre || wb) && (rn != 4'd15) && !(ld && rd == rn);

    check_eq("ready_before_accept", 32'(req_ready), 32'd1);
    inst = 32'd0;
    inst[L_BIT] = ld; inst[B_BIT] = by; inst[P_BIT] = pre;
    inst[U_BIT] = up; inst[W_BIT] = wb;
    req_valid  = 1'b1;
    req_load   = inst[L_BIT];
    req_byte   = inst[B_BIT];
    req_pre    = inst[P_BIT];
    req_up     = inst[U_BIT];
    req_wb     = inst[W_BIT];
    req_rn     = rn;
    req_rd     = rd;
    req_base   = base;
    req_offset = off;
    req_sdata  = sdata;
    step();
    req_valid = 1'($urandom);
    scramble_req();

    acked = 0;
    for (int i = 0; i < int'(TO); i++) begin
      check_eq("mem_req", 32'(mem_req), 32'd1);
      check_eq("mem_addr", mem_addr, x_addr);
      check_eq("mem_be", 32'(mem_be), 32'(x_be));
      check_eq("mem_we", 32'(mem_we), 32'(!ld));
      check_eq("mem_wdata", mem_wdata, x_wdata);
      check_eq("ready_busy", 32'(req_ready), 32'd0);
      check_eq("rsp_early", 32'(rsp_valid), 32'd0);
      if (i == int'(waits)) begin
        mem_ack = 1'b1; mem_rdata = rdata;
        acked = 1;
      end else begin
        mem_ack = 1'b0; mem_rdata = $urandom;
      end
      step();
      mem_ack = 1'b0; mem_rdata = $urandom;
      if (acked) break;
    end

    check_eq("rsp_valid", 32'(rsp_valid), 32'd1);
    check_eq("mem_req_in_rsp", 32'(mem_req), 32'd0);
    check_eq("rsp_fault", 32'(rsp_fault), 32'(fault));
    check_eq("rsp_ld_we", 32'(rsp_ld_we), 32'(x_ldwe));
    check_eq("rsp_wb_we", 32'(rsp_wb_we), 32'(x_wbwe));
    check_eq("rsp_rd", 32'(rsp_rd), 32'(rd));
    check_eq("rsp_rn", 32'(rsp_rn), 32'(rn));
    check_eq("rsp_base", rsp_base, upd);
    if (x_ldwe) check_eq("rsp_data", rsp_data, x_data);
    req_valid = 1'b0;
    step();
    check_eq("rsp_pulse_end", 32'(rsp_valid), 32'd0);
    check_eq("rsp_data_idle", rsp_data, 32'd0);
    check_eq("ready_after", 32'(req_ready), 32'd1);
  endtask

  initial begin
    reset = 1'b1; req_valid = 1'b0; mem_ack = 1'b0; mem_rdata = 32'd0;
    scramble_req();
    #12;
    check_eq("rst_ready", 32'(req_ready), 32'd1);
    check_eq("rst_mem_req", 32'(mem_req), 32'd0);
    check_eq("rst_mem_addr", mem_addr, 32'd0);
    check_eq("rst_rsp_valid", 32'(rsp_valid), 32'd0);
    check_eq("rst_rsp_base", rsp_base, 32'd0);
    @(negedge clk); reset = 1'b0;
    step();

    // Directed cases
    do_txn(1, 0, 1, 1, 0, 4'd1, 4'd2, 32'h100, 12'd4, 32'd0, 32'hDEADBEEF, 0);
    do_txn(0, 1, 0, 0, 0, 4'd3, 4'd4, 32'h203, 12'd3, 32'h12345678, 32'd0, 0);
    do_txn(1, 0, 1, 1, 0, 4'd5, 4'd6, 32'h100, 12'd2, 32'd0, 32'h11223344, 0);
    do_txn(1, 1, 1, 1, 1, 4'd7, 4'd8, 32'h1000, 12'd5, 32'd0, 32'hA1B2C3D4, 5);
    do_txn(1, 0, 0, 1, 0, 4'd9, 4'd9, 32'h40, 12'd8, 32'd0, 32'h55AA55AA, 2);
    do_txn(0, 0, 0, 1, 0, 4'd15, 4'd1, 32'h80, 12'd8, 32'hCAFEF00D, 32'd0, 1);
    do_txn(1, 0, 1, 0, 1, 4'd2, 4'd3, 32'h10, 12'h20, 32'd0, 32'h01020304, TO - 1);
    do_txn(1, 0, 1, 1, 1, 4'd2, 4'd3, 32'h200, 12'd4, 32'd0, 32'h0, NEVER);

    // Randomized transfers
    for (int n = 0; n < 150; n++) begin
      int unsigned w;
      w = $urandom_range(0, 9);
      if (w > 4) w = (w == 9) ? NEVER : $urandom_range(0, TO - 1);
      do_txn(1'($urandom), 1'($urandom), 1'($urandom), 1'($urandom), 1'($urandom),
             4'($urandom), 4'($urandom), $urandom, 12'($urandom),
             $urandom, $urandom, w);
    end

    // Reset in the middle of an access
    req_valid = 1'b1; req_load = 1'b1; req_byte = 1'b0; req_pre = 1'b1;
    req_up = 1'b1; req_wb = 1'b0; req_rn = 4'd1; req_rd = 4'd2;
    req_base = 32'h300; req_offset = 12'd0;
    step();
    req_valid = 1'b0;
    step();
    check_eq("mid_mem_req", 32'(mem_req), 32'd1);
    #2 reset = 1'b1;
    #1;
    check_eq("rst_async_mem_req", 32'(mem_req), 32'd0);
    check_eq("rst_async_rsp", 32'(rsp_valid), 32'd0);
    check_eq("rst_async_ready", 32'(req_ready), 32'd1);
    @(negedge clk); reset = 1'b0;
    for (int i = 0; i < int'(TO) + 2; i++) begin
      step();
      check_eq("post_rst_no_rsp", 32'(rsp_valid), 32'd0);
      check_eq("post_rst_ready", 32'(req_ready), 32'd1);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/ldst_unit.md
# ldst_unit

Load/store unit for the single-cycle ARM-subset core. It accepts one decoded LDR/STR (single data transfer, immediate offset) from the execute stage and computes the effective and updated base address. It then runs a variable-latency data-memory transaction and returns load data and base writeback to the register-file write port. It sits directly downstream of instruction decode/execute and upstream of the data memory.

## Interface
- TIMEOUT, 255: maximum cycles `mem_req` may stay high without `mem_ack` before the access aborts; must be ≥1.

- clk  in  1  clock; all state changes on rising edge
- reset  in  1  asynchronous, active-high reset
- req_valid  in  1  execute stage presents a transfer
- req_ready  out  1  unit idle; transfer accepted when req_valid && req_ready at a rising edge
- req_load  in  1  1 = LDR, 0 = STR (inst[20])
- req_byte  in  1  1 = byte, 0 = word (inst[22])
- req_pre  in  1  1 = pre-index, 0 = post-index (inst[24])
- req_up  in  1  1 = add offset, 0 = subtract (inst[23])
- req_wb  in  1  write-back request for pre-index (inst[21])
- req_rn  in  4  base register number
- req_rd  in  4  transfer register number
- req_base  in  32  Rn value (PC+8 already applied by core when Rn = 15)
- req_offset  in  12  unsigned immediate offset
- req_sdata  in  32  Rd value for stores
- mem_req  out  1  memory access request
- mem_we  out  1  1 = write
- mem_addr  out  32  word-aligned address (bits [1:0] = 0)
- mem_be  out  4  byte enables
- mem_wdata  out  32  write data
- mem_ack  in  1  access complete; mem_rdata valid in the same cycle
- mem_rdata  in  32  read data
- rsp_valid  out  1  one-cycle response pulse
- rsp_fault  out  1  access timed out
- rsp_ld_we  out  1  write rsp_data into rsp_rd
- rsp_rd  out  4  load destination
- rsp_data  out  32  aligned load data
- rsp_wb_we  out  1  write rsp_base into rsp_rn
- rsp_rn  out  4  base register
- rsp_base  out  32  updated base

## Operation
- FSM states: IDLE, ACCESS, RESP. On reset, all outputs are 0 except req_ready = 1. The state is IDLE and the wait counter is 0.
- IDLE: req_ready = 1. On acceptance, the unit registers all request fields and goes to ACCESS.
- Updated base: `req_base ± zero-extended offset`, modulo 2^32.
- Effective address: the updated base if req_pre = 1, otherwise req_base.
- Writeback: enabled if (req_pre = 0) or req_wb. It is suppressed when rn = 15. It is also suppressed for a load with rd = rn, in which case the loaded value wins.
- Word access: mem_be = 1111 and mem_wdata = sdata. Load data is rotated right by 8 × addr[1:0] (ARMv4 unaligned rule).
- Byte access: mem_be = 1 << addr[1:0] and mem_wdata = {4{sdata[7:0]}}. Load data is the zero-extended selected lane.
- ACCESS: mem_req = 1. mem_addr, mem_we, mem_be and mem_wdata are held constant until exit.
  - mem_ack high → capture and align the data, go to RESP.
  - mem_ack low → wait counter increments. When the counter reaches TIMEOUT → fault, go to RESP.
  - An ack arriving on the TIMEOUT-th cycle wins over the fault.
- RESP: rsp_valid = 1 for exactly one cycle, then return to IDLE.
  - Normal load: rsp_ld_we = 1. Store: rsp_ld_we = 0.
  - Fault: rsp_ld_we = 0 and rsp_wb_we = 0.
  - rsp_* outputs are 0 whenever rsp_valid = 0.
- Reset asserted in any state: mem_req and rsp_valid drop immediately (asynchronously). The in-flight transfer is discarded with no response.

## Timing
- Acceptance at edge E0 → mem_req is high from E0 onward.
- Ack sampled at edge Ea → rsp_valid is high from Ea to Ea+1.
- req_ready is high again from Ea+1.
- Zero-wait memory (ack in the first ACCESS cycle): 2 cycles from acceptance to response. Minimum spacing between acceptances is 3 edges.
- Fault: rsp_valid is asserted TIMEOUT cycles after mem_req first rises.
- req_* inputs are ignored outside IDLE. No back-pressure on rsp.

## Structure
- Shared package cpu_pkg holds:
  - instruction field positions for L/B/P/U/W bits
  - register constant r15
  - FSM state encoding typedef
- Sub-module ldst_align (combinational) holds the byte-enable generation, store replication and load rotate/extract. ldst_unit holds the FSM, address arithmetic, registers and timeout counter.

## Test plan
- LDR word, pre, up, base 0x100, offset 4, zero-wait, rdata 0xDEADBEEF → mem_addr 0x104, be 1111, rsp_data 0xDEADBEEF, rsp_ld_we 1, rsp_wb_we 0.
- STRB, post, down, base 0x203, offset 3, sdata 0x12345678 → mem_addr 0x200, be 1000, wdata 0x78787878, rsp_base 0x200, rsp_wb_we 1.
- LDR word at effective address 0x102, rdata 0x11223344 → mem_addr 0x100, rsp_data 0x33441122.
- Ack after 5 wait cycles → mem_req and address stable for 6 cycles, req_ready 0 throughout, single rsp_valid pulse on the cycle after ack.
- TIMEOUT = 8, ack never asserted → mem_req drops after 8 cycles, rsp_valid with rsp_fault 1, rsp_ld_we 0, rsp_wb_we 0.
- Reset asserted mid-ACCESS → mem_req 0 without a clock edge, no rsp_valid, req_ready 1 after release.
